// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from the TX FIFO and serializes them as start/data/[parity]/stop frames.
// Define UART_TX_PARITY_EN to add the parity_en/parity_odd ports and the PARITY bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_en,
  input  logic                  parity_odd,
`endif
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  txd,
  output logic                  busy
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  stop2_q;
  logic                  stop_sec;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_bit;
`endif

  logic can_fetch, bit_end;
  assign can_fetch = tx_enable && !fifo_empty;
  assign bit_end   = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      txd        <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      stop_sec   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: if (can_fetch) begin
          state      <= FETCH;
          fifo_rd_en <= 1'b1;
          busy       <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          // Frame configuration is frozen here so mid-frame edits only affect the next frame.
          shreg   <= fifo_rd_data;
          div_q   <= baud_div;
          div_cnt <= baud_div;
          stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
          par_en_q <= parity_en;
          par_bit  <= (^fifo_rd_data) ^ parity_odd;
`endif
          txd     <= 1'b0;
          state   <= START;
        end
        START: if (!bit_end) div_cnt <= div_cnt - DIV_WIDTH'(1);
        else begin
          div_cnt <= div_q;
          bit_cnt <= '0;
          txd     <= shreg[0];
          shreg   <= shreg >> 1;
          state   <= DATA;
        end
        DATA: if (!bit_end) div_cnt <= div_cnt - DIV_WIDTH'(1);
        else begin
          div_cnt <= div_q;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              txd   <= par_bit;
              state <= PARITY;
            end else
`endif
            begin
              txd      <= 1'b1;
              stop_sec <= 1'b0;
              state    <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (!bit_end) div_cnt <= div_cnt - DIV_WIDTH'(1);
        else begin
          div_cnt  <= div_q;
          txd      <= 1'b1;
          stop_sec <= 1'b0;
          state    <= STOP;
        end
`endif
        STOP: if (!bit_end) div_cnt <= div_cnt - DIV_WIDTH'(1);
        else if (stop2_q && !stop_sec) begin
          stop_sec <= 1'b1;
          div_cnt  <= div_q;
        end else if (can_fetch) begin
          state      <= FETCH;
          fifo_rd_en <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
